rf_failsafe_ramp: RTL and testbench

Downstream consumer of the watchdog timer's triggered/warning outputs. It gates the AM carrier amplitude fed to the modulator/DAC path.
- On watchdog timeout, ramps amplitude to zero and latches a fault; the fault clears only on an explicit host re-arm.
- Soft ramps avoid spectral splatter and PA transients; the latched fault stops an unattended transmitter from restarting by itself.

---
 rtl/rf_failsafe_pkg.sv | 37 +++
 rtl/rf_failsafe_ramp_tick.sv | 28 ++
 rtl/rf_failsafe_ramp.sv | 157 +++++++++++++++
 tb/tb_rf_failsafe_ramp.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_failsafe_pkg.sv
// Shared definitions for the RF failsafe ramp block: FSM state encodings,
// default amplitude width and saturating arithmetic helpers.
package rf_failsafe_pkg;

    // Encodings are visible on the debug status port and must stay fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_NORMAL    = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int unsigned AMP_W_DEFAULT = 16;

    // Working width of the helpers; callers zero-extend narrower words.
    localparam int unsigned HELP_W = 64;

    // Returns min(a + b, lim) without wrapping.
    function automatic logic [HELP_W-1:0] sat_add(input logic [HELP_W-1:0] a,
                                                  input logic [HELP_W-1:0] b,
                                                  input logic [HELP_W-1:0] lim);
        logic [HELP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s > {1'b0, lim}) begin
            return lim;
        end
        return s[HELP_W-1:0];
    endfunction

    // Returns a - b, floored at zero.
    function automatic logic [HELP_W-1:0] sat_sub(input logic [HELP_W-1:0] a,
                                                  input logic [HELP_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/rf_failsafe_ramp_tick.sv
// ramp_tick_gen: RAMP_DIV prescaler. Counts only while run=1, clears on clr,
// and pulses tick on the cycle the count equals DIV-1 before wrapping to 0.
module ramp_tick_gen #(
    parameter int unsigned DIV = 100
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    assign tick = run && (cnt == CNT_W'(DIV - 1));

    // Prescaler counter: held at zero when idle or cleared, wraps after a tick.
    always_ff @(posedge clk) begin
        if (!rstn || clr || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/rf_failsafe_ramp.sv
// rf_failsafe_ramp: gates the AM carrier amplitude. Ramps up on enable, ramps
// down on disable or watchdog timeout; a watchdog ramp ends in a sticky FAULT
// that only a host rearm (with the watchdog quiet) clears.
// Optional build macro: RF_FAILSAFE_WARN_ATTEN_EN (attenuate by WARN_SHIFT
// while wd_warning is high in NORMAL).
module rf_failsafe_ramp
    import rf_failsafe_pkg::*;
#(
    parameter int unsigned AMP_W      = AMP_W_DEFAULT,
    parameter int unsigned RAMP_STEP  = 256,
    parameter int unsigned RAMP_DIV   = 100,
    parameter int unsigned WARN_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic             wd_triggered,
    input  logic             wd_warning,
    input  logic             rearm,
    input  logic [AMP_W-1:0] amp_in,
    output logic [AMP_W-1:0] amp_out,
    output logic             rf_en,
    output logic             fault_latched,
    output logic [2:0]       state
);

    state_t           state_q, state_d;
    logic [AMP_W-1:0] level_q, level_d;
    logic             cause_wd_q, cause_wd_d;
    logic             rf_en_q, fault_q;
    logic             tick;
    logic             ramping;
    logic [HELP_W-1:0] step_w;
    logic [HELP_W-1:0] up_w, down_w;

    function automatic logic [HELP_W-1:0] ext(input logic [AMP_W-1:0] v);
        return {{(HELP_W - AMP_W){1'b0}}, v};
    endfunction

    assign step_w  = HELP_W'(RAMP_STEP);
    assign up_w    = sat_add(ext(level_q), step_w, ext(amp_in));
    assign down_w  = sat_sub(ext(level_q), step_w);
    assign ramping = (state_q == ST_RAMP_UP) || (state_q == ST_RAMP_DOWN);

    ramp_tick_gen #(
        .DIV(RAMP_DIV)
    ) u_tick (
        .clk (clk),
        .rstn(rstn),
        .run (ramping),
        .clr (state_d != state_q),
        .tick(tick)
    );

`ifndef RF_FAILSAFE_WARN_ATTEN_EN
    logic unused_warn;
    assign unused_warn = ^{wd_warning, WARN_SHIFT[0]};
`endif

    // Next-state, next-level and fault-cause selection.
    always_comb begin
        state_d    = state_q;
        level_d    = level_q;
        cause_wd_d = cause_wd_q;
        case (state_q)
            ST_IDLE: begin
                level_d    = '0;
                cause_wd_d = 1'b0;
                if (enable && !wd_triggered) begin
                    state_d = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (wd_triggered) begin
                    state_d    = ST_RAMP_DOWN;
                    cause_wd_d = 1'b1;
                end else if (!enable) begin
                    state_d    = ST_RAMP_DOWN;
                    cause_wd_d = 1'b0;
                end else if (amp_in < level_q) begin
                    level_d = amp_in;
                    state_d = ST_NORMAL;
                end else if (tick) begin
                    level_d = up_w[AMP_W-1:0];
                    if (up_w[AMP_W-1:0] == amp_in) begin
                        state_d = ST_NORMAL;
                    end
                end
            end
            ST_NORMAL: begin
                if (wd_triggered) begin
                    state_d    = ST_RAMP_DOWN;
                    cause_wd_d = 1'b1;
                end else if (!enable) begin
                    state_d    = ST_RAMP_DOWN;
                    cause_wd_d = 1'b0;
                end else begin
`ifdef RF_FAILSAFE_WARN_ATTEN_EN
                    level_d = wd_warning ? (amp_in >> WARN_SHIFT) : amp_in;
`else
                    level_d = amp_in;
`endif
                end
            end
            ST_RAMP_DOWN: begin
                if (wd_triggered) begin
                    cause_wd_d = 1'b1;
                end
                // Reaching zero (already there, or on this tick) ends the ramp.
                if (level_q == '0) begin
                    state_d = cause_wd_d ? ST_FAULT : ST_IDLE;
                end else if (tick) begin
                    level_d = down_w[AMP_W-1:0];
                    if (down_w[AMP_W-1:0] == '0) begin
                        state_d = cause_wd_d ? ST_FAULT : ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                level_d = '0;
                if (rearm && !wd_triggered) begin
                    state_d    = ST_IDLE;
                    cause_wd_d = 1'b0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                level_d    = '0;
                cause_wd_d = 1'b0;
            end
        endcase
    end

    // State, amplitude and registered status outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            level_q    <= '0;
            cause_wd_q <= 1'b0;
            rf_en_q    <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            cause_wd_q <= cause_wd_d;
            rf_en_q    <= (state_d == ST_RAMP_UP) || (state_d == ST_NORMAL) ||
                          (state_d == ST_RAMP_DOWN);
            fault_q    <= (state_d == ST_FAULT);
        end
    end

    assign amp_out       = level_q;
    assign rf_en         = rf_en_q;
    assign fault_latched = fault_q;
    assign state         = state_q;

endmodule

// File: tb/tb_rf_failsafe_ramp.sv
// Directed self-checking bench for rf_failsafe_ramp (AMP_W=16, RAMP_STEP=256,
// RAMP_DIV=4, WARN_SHIFT=1).
module tb_rf_failsafe_ramp;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        wd_triggered;
    logic        wd_warning;
    logic        rearm;
    logic [15:0] amp_in;
    logic [15:0] amp_out;
    logic        rf_en;
    logic        fault_latched;
    logic [2:0]  state;

    int total = 0;
    int bad   = 0;

    rf_failsafe_ramp #(
        .AMP_W     (16),
        .RAMP_STEP (256),
        .RAMP_DIV  (4),
        .WARN_SHIFT(1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .wd_triggered (wd_triggered),
        .wd_warning   (wd_warning),
        .rearm        (rearm),
        .amp_in       (amp_in),
        .amp_out      (amp_out),
        .rf_en        (rf_en),
        .fault_latched(fault_latched),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; wd_triggered = 1'b0; wd_warning = 1'b0;
        rearm = 1'b0; amp_in = 16'h0000;
        step(); step();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state); end
        total++; if (amp_out !== 16'h0000) begin bad++; $display("FAIL rst_amp got=%h exp=0000", amp_out); end
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL rst_rf_en got=%b exp=0", rf_en); end
        total++; if (fault_latched !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", fault_latched); end
    endtask

    task automatic test_ramp_up();
        int n;
        logic [15:0] amp_max;
        logic [15:0] amp_at4;
        rstn = 1'b1; enable = 1'b1; amp_in = 16'h1000;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL up_enter got=%0d exp=1", state); end
        total++; if (rf_en !== 1'b1) begin bad++; $display("FAIL up_rf_en got=%b exp=1", rf_en); end
        n = 0; amp_max = amp_out; amp_at4 = 16'hFFFF;
        while (state === 3'd1 && n < 200) begin
            step(); n++;
            if (amp_out > amp_max) amp_max = amp_out;
            if (n == 4) amp_at4 = amp_out;
        end
        total++; if (n !== 64) begin bad++; $display("FAIL up_cycles got=%0d exp=64", n); end
        total++; if (amp_at4 !== 16'h0100) begin bad++; $display("FAIL up_first_tick got=%h exp=0100", amp_at4); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL up_normal got=%0d exp=2", state); end
        total++; if (amp_out !== 16'h1000) begin bad++; $display("FAIL up_amp got=%h exp=1000", amp_out); end
        total++; if (amp_max > 16'h1000) begin bad++; $display("FAIL up_overshoot got=%h exp<=1000", amp_max); end
    endtask

    task automatic test_wd_fault();
        int n;
        amp_in = 16'h0800;
        step();
        total++; if (amp_out !== 16'h0800) begin bad++; $display("FAIL norm_follow got=%h exp=0800", amp_out); end
        wd_triggered = 1'b1;
        step();
        wd_triggered = 1'b0;
        total++; if (state !== 3'd3) begin bad++; $display("FAIL wd_down got=%0d exp=3", state); end
        total++; if (amp_out !== 16'h0800) begin bad++; $display("FAIL wd_nojump got=%h exp=0800", amp_out); end
        n = 0;
        while (state === 3'd3 && n < 200) begin step(); n++; end
        total++; if (n !== 32) begin bad++; $display("FAIL wd_down_cycles got=%0d exp=32", n); end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL wd_fault_state got=%0d exp=4", state); end
        total++; if (amp_out !== 16'h0000) begin bad++; $display("FAIL wd_fault_amp got=%h exp=0000", amp_out); end
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL wd_fault_rf_en got=%b exp=0", rf_en); end
        total++; if (fault_latched !== 1'b1) begin bad++; $display("FAIL wd_fault_flag got=%b exp=1", fault_latched); end
        step(); step(); step();
        total++; if (state !== 3'd4) begin bad++; $display("FAIL fault_sticky got=%0d exp=4", state); end
    endtask

    task automatic test_rearm();
        wd_triggered = 1'b1; rearm = 1'b1;
        step();
        rearm = 1'b0;
        total++; if (state !== 3'd4) begin bad++; $display("FAIL rearm_blocked got=%0d exp=4", state); end
        total++; if (fault_latched !== 1'b1) begin bad++; $display("FAIL rearm_blocked_flag got=%b exp=1", fault_latched); end
        wd_triggered = 1'b0; rearm = 1'b1;
        step();
        rearm = 1'b0;
        total++; if (state !== 3'd0) begin bad++; $display("FAIL rearm_idle got=%0d exp=0", state); end
        total++; if (fault_latched !== 1'b0) begin bad++; $display("FAIL rearm_flag got=%b exp=0", fault_latched); end
        step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL rearm_restart got=%0d exp=1", state); end
    endtask

    task automatic test_disable();
        int n;
        amp_in = 16'h1000;
        n = 0;
        while (state !== 3'd2 && n < 200) begin step(); n++; end
        total++; if (amp_out !== 16'h1000) begin bad++; $display("FAIL dis_start got=%h exp=1000", amp_out); end
        enable = 1'b0;
        step();
        total++; if (state !== 3'd3) begin bad++; $display("FAIL dis_down got=%0d exp=3", state); end
        n = 0;
        while (state === 3'd3 && n < 200) begin step(); n++; end
        total++; if (n !== 64) begin bad++; $display("FAIL dis_cycles got=%0d exp=64", n); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL dis_idle got=%0d exp=0", state); end
        total++; if (fault_latched !== 1'b0) begin bad++; $display("FAIL dis_flag got=%b exp=0", fault_latched); end
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL dis_rf_en got=%b exp=0", rf_en); end
        enable = 1'b1;
        n = 0;
        while (state !== 3'd2 && n < 200) begin step(); n++; end
        enable = 1'b0;
        step();
        for (int i = 0; i < 10; i++) step();
        total++; if (amp_out !== 16'h0E00) begin bad++; $display("FAIL dis_mid got=%h exp=0E00", amp_out); end
        wd_triggered = 1'b1;
        step();
        wd_triggered = 1'b0;
        total++; if (amp_out !== 16'h0E00) begin bad++; $display("FAIL upg_nojump got=%h exp=0E00", amp_out); end
        n = 0;
        while (state === 3'd3 && n < 200) begin step(); n++; end
        total++; if (state !== 3'd4) begin bad++; $display("FAIL upg_fault got=%0d exp=4", state); end
        total++; if (fault_latched !== 1'b1) begin bad++; $display("FAIL upg_flag got=%b exp=1", fault_latched); end
        rearm = 1'b1;
        step();
        rearm = 1'b0;
        step();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL upg_rearm_idle got=%0d exp=0", state); end
    endtask

    task automatic test_clamp_reset();
        enable = 1'b1; amp_in = 16'h1000;
        step();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL clamp_enter got=%0d exp=1", state); end
        for (int i = 0; i < 24; i++) step();
        total++; if (amp_out !== 16'h0600) begin bad++; $display("FAIL clamp_pre got=%h exp=0600", amp_out); end
        amp_in = 16'h0400;
        step();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL clamp_state got=%0d exp=2", state); end
        total++; if (amp_out !== 16'h0400) begin bad++; $display("FAIL clamp_amp got=%h exp=0400", amp_out); end
        amp_in = 16'h1000; rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
        for (int i = 0; i < 8; i++) step();
        total++; if (amp_out !== 16'h0200) begin bad++; $display("FAIL midramp_pre got=%h exp=0200", amp_out); end
        rstn = 1'b0;
        step();
        total++; if (amp_out !== 16'h0000) begin bad++; $display("FAIL midramp_amp got=%h exp=0000", amp_out); end
        total++; if (state !== 3'd0) begin bad++; $display("FAIL midramp_state got=%0d exp=0", state); end
        total++; if (rf_en !== 1'b0) begin bad++; $display("FAIL midramp_rf_en got=%b exp=0", rf_en); end
        rstn = 1'b1;
    endtask

    task automatic test_warn();
        int n;
        logic [15:0] exp_warn;
`ifdef RF_FAILSAFE_WARN_ATTEN_EN
        exp_warn = 16'h0800;
`else
        exp_warn = 16'h1000;
`endif
        n = 0;
        while (state !== 3'd2 && n < 200) begin step(); n++; end
        total++; if (amp_out !== 16'h1000) begin bad++; $display("FAIL warn_base got=%h exp=1000", amp_out); end
        wd_warning = 1'b1;
        step();
        total++; if (amp_out !== exp_warn) begin bad++; $display("FAIL warn_atten got=%h exp=%h", amp_out, exp_warn); end
        wd_warning = 1'b0;
        step();
        total++; if (amp_out !== 16'h1000) begin bad++; $display("FAIL warn_restore got=%h exp=1000", amp_out); end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_wd_fault();
        test_rearm();
        test_disable();
        test_clamp_reset();
        test_warn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
